// File: rtl/rc522_spi_burst.sv
// rc522_spi_burst: SPI mode-0 burst register master for MFRC522; RC522_UID_BCC_EN adds the UID BCC check.
module rc522_spi_burst #(
  parameter int CLK_DIV   = 4,
  parameter int MAX_BYTES = 5,
  parameter int LEN_W     = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   rw,
  input  logic [5:0]             addr,
  input  logic [LEN_W-1:0]       len,
  input  logic [8*MAX_BYTES-1:0] wdata,
  output logic [8*MAX_BYTES-1:0] rdata,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic                   bcc_ok,
  output logic                   cs,
  output logic                   sck,
  output logic                   mosi,
  input  logic                   miso
);
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;
  state_t state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [2:0] bit_q, bit_d;
  logic [LEN_W-1:0] byte_q, byte_d, len_q, len_d;
  logic [7:0] rx_q, rx_d, nb;
  logic [5:0] addr_q, addr_d;
  logic [8*MAX_BYTES-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic rw_q, rw_d, sck_q, sck_d, cs_q, cs_d, mosi_q, mosi_d;
  logic busy_q, busy_d, done_q, done_d, err_q, err_d, bcc_q, bcc_d, wrap;
  function automatic logic [7:0] frame_byte(input logic [LEN_W-1:0] j);
    if (j == '0) return {rw_q, addr_q, 1'b0};
    if (rw_q) return j == len_q ? 8'h00 : {rw_q, addr_q, 1'b0};
    return wdata_q[8*(int'(j)-1) +: 8];
  endfunction
  always_comb begin
    state_d = state_q;
    div_d = div_q;
    bit_d = bit_q;
    byte_d = byte_q;
    len_d = len_q;
    rx_d = rx_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    rw_d = rw_q;
    sck_d = sck_q;
    cs_d = cs_q;
    mosi_d = mosi_q;
    busy_d = busy_q;
    done_d = 1'b0;
    err_d = 1'b0;
    bcc_d = bcc_q;
    wrap = div_q == DW'(CLK_DIV-1);
    nb = frame_byte(bit_q == 3'd7 ? byte_q + 1'b1 : byte_q);
    case (state_q)
      IDLE: begin
        div_d = '0;
        if (start && (len == '0 || len > LEN_W'(MAX_BYTES))) err_d = 1'b1;
        else if (start) begin
          state_d = SHIFT;
          rw_d = rw;
          addr_d = addr;
          len_d = len;
          wdata_d = wdata;
          rdata_d = '0;
          bcc_d = 1'b0;
          cs_d = 1'b0;
          busy_d = 1'b1;
          mosi_d = rw;
          bit_d = '0;
          byte_d = '0;
        end
      end
      SHIFT: begin
        div_d = wrap ? '0 : div_q + 1'b1;
        if (wrap) begin
          sck_d = ~sck_q;
          if (!sck_q) rx_d = {rx_q[6:0], miso};
          else begin
            // each completed byte after the address byte lands in rdata
            if (bit_q == 3'd7 && byte_q != '0 && rw_q) rdata_d[8*(int'(byte_q)-1) +: 8] = rx_q;
            if (bit_q == 3'd7 && byte_q == len_q) state_d = HOLD;
            else begin
              bit_d = bit_q + 1'b1;
              byte_d = bit_q == 3'd7 ? byte_q + 1'b1 : byte_q;
              mosi_d = nb[~bit_d];
            end
          end
        end
      end
      HOLD: begin
        div_d = wrap ? '0 : div_q + 1'b1;
        if (wrap) begin
          state_d = IDLE;
          cs_d = 1'b1;
          busy_d = 1'b0;
          done_d = 1'b1;
          mosi_d = 1'b0;
`ifdef RC522_UID_BCC_EN
          begin
            logic [7:0] x;
            x = '0;
            for (int i = 0; i < MAX_BYTES && i < 5; i++) x ^= rdata_q[8*i +: 8];
            bcc_d = rw_q && len_q == LEN_W'(5) && x == 8'h00;
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      div_q <= '0;
      bit_q <= '0;
      byte_q <= '0;
      len_q <= '0;
      rx_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      rw_q <= 1'b0;
      sck_q <= 1'b0;
      cs_q <= 1'b1;
      mosi_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      bcc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q <= div_d;
      bit_q <= bit_d;
      byte_q <= byte_d;
      len_q <= len_d;
      rx_q <= rx_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      rw_q <= rw_d;
      sck_q <= sck_d;
      cs_q <= cs_d;
      mosi_q <= mosi_d;
      busy_q <= busy_d;
      done_q <= done_d;
      err_q <= err_d;
      bcc_q <= bcc_d;
    end
  end
  assign rdata = rdata_q;
  assign busy = busy_q;
  assign done = done_q;
  assign err = err_q;
  assign bcc_ok = bcc_q;
  assign cs = cs_q;
  assign sck = sck_q;
  assign mosi = mosi_q;
endmodule

// File: tb/tb_rc522_spi_burst.sv
// tb_rc522_spi_burst: frame-level model of rc522_spi_burst checked every cycle, plus literal expectations.
module tb_rc522_spi_burst;
  localparam int C = 2, MB = 5, LW = 3;
  logic clk = 0, rst = 1, start = 0, rw = 0, miso = 0;
  logic [5:0] addr = 0;
  logic [LW-1:0] len = 0;
  logic [8*MB-1:0] wdata = 0, rdata;
  logic busy, done, err, bcc_ok, cs, sck, mosi;
  rc522_spi_burst #(.CLK_DIV(C), .MAX_BYTES(MB), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst), .start(start), .rw(rw), .addr(addr), .len(len), .wdata(wdata),
    .rdata(rdata), .busy(busy), .done(done), .err(err), .bcc_ok(bcc_ok),
    .cs(cs), .sck(sck), .mosi(mosi), .miso(miso));
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int checks = 0, failures = 0;
  bit m_act = 0;
  int m_T = 0, m_B = 0, m_kill = 1 << 30, m_err_at = -1;
  logic m_bits [0:47];
  logic m_mbits [0:47];
  logic [39:0] m_rd = 0, m_rdv = 0;
  logic m_bcc = 0, m_bccv = 0, psck = 0;
  int dn_n = 0, er_n = 0, dn_cyc = 0, sck_n = 0, capi = 0;
  logic [7:0] cap [0:5];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask
  always @(negedge clk) begin
    int k;
    logic [4:0] e;
    if (m_act && cyc >= m_kill) m_act = 0;
    k = cyc - m_T - 1;
    if (m_act && k >= 0) begin
      if (k < 2*C*m_B) begin
        e = {1'b0, (k % (2*C)) >= C, 1'b1, 1'b0, 1'b0};
        chk("mosi", mosi, m_bits[k/(2*C)]);
      end else if (k < 2*C*m_B + C) e = 5'b00100;
      else begin
        e = 5'b10010;
        chk("rdata_done", rdata, m_rd);
        chk("bcc_done", bcc_ok, m_bcc);
        m_rdv = m_rd;
        m_bccv = m_bcc;
        m_act = 0;
      end
    end else begin
      e = {4'b1000, cyc == m_err_at};
      if (!m_act) begin
        chk("rdata_idle", rdata, m_rdv);
        chk("bcc_idle", bcc_ok, m_bccv);
      end
    end
    chk("cs_sck_busy_done_err", {cs, sck, busy, done, err}, e);
    if (done) begin dn_n++; dn_cyc = cyc; end
    if (err) er_n++;
    if (sck && !psck && capi < 48) begin
      sck_n++;
      cap[capi/8] = {cap[capi/8][6:0], mosi};
      capi++;
    end
    psck = sck;
  end
  always @(posedge clk) begin
    #2;
    miso = (m_act && cyc > m_T && cyc - m_T - 1 < 2*C*m_B) ? m_mbits[(cyc-m_T-1)/(2*C)] : 1'b0;
  end
  task automatic frame(input logic r, input logic [5:0] a, input int l, input logic [39:0] w, input logic [47:0] mb);
    logic [7:0] hb, bt, x;
    logic [39:0] rd;
    @(posedge clk); #1;
    start = 1; rw = r; addr = a; len = LW'(l); wdata = w;
    if (l >= 1 && l <= MB && !m_act) begin
      hb = {r, a, 1'b0};
      rd = 0;
      for (int j = 0; j <= l; j++) begin
        if (j == 0) bt = hb;
        else if (r) bt = (j == l) ? 8'h00 : hb;
        else bt = w[8*(j-1) +: 8];
        for (int b = 0; b < 8; b++) begin
          m_bits[8*j+b] = bt[7-b];
          m_mbits[8*j+b] = mb[8*j+7-b];
        end
        if (r && j > 0) rd[8*(j-1) +: 8] = mb[8*j +: 8];
      end
      m_rd = rd;
      x = rd[7:0] ^ rd[15:8] ^ rd[23:16] ^ rd[31:24];
`ifdef RC522_UID_BCC_EN
      m_bcc = r && l == 5 && x == rd[39:32];
`else
      m_bcc = 0 & x[0];
`endif
      m_T = cyc; m_B = 8*(l+1); m_kill = 1 << 30; capi = 0; sck_n = 0; m_act = 1;
    end else if (!m_act) m_err_at = cyc + 1;
    @(posedge clk); #1;
    start = 0;
  endtask
  task automatic wait_frame();
    repeat (2*C*m_B + C + 3) @(posedge clk);
    #1;
  endtask
  initial begin
    int t, n0, e0;
    logic [7:0] ex [0:3];
    logic bexp;
`ifdef RC522_UID_BCC_EN
    bexp = 1;
`else
    bexp = 0;
`endif
    repeat (3) @(posedge clk);
    #1 rst = 0;
    frame(0, 6'h01, 1, 40'h0F, 48'h0);
    t = m_T;
    wait_frame();
    chk("t1_done_latency", dn_cyc - t, 67);
    chk("t1_mosi_b0", cap[0], 8'h02);
    chk("t1_mosi_b1", cap[1], 8'h0F);
    chk("t1_sck_pulses", sck_n, 16);
    chk("t1_rdata", rdata, 40'h0);
    frame(1, 6'h09, 3, 40'h0, 48'h00_00_33_22_11_AA);
    wait_frame();
    chk("t2_rdata", rdata, 40'h00_00_33_22_11);
    ex = '{8'h92, 8'h92, 8'h92, 8'h00};
    for (int i = 0; i < 4; i++) chk("t2_mosi_byte", cap[i], ex[i]);
    frame(1, 6'h09, 5, 40'h0, 48'hAA_1A_3C_04_88_00);
    wait_frame();
    chk("t3_rdata", rdata, 40'hAA_1A_3C_04_88);
    chk("t3_bcc_good", bcc_ok, bexp);
    frame(1, 6'h09, 5, 40'h0, 48'hAB_1A_3C_04_88_00);
    wait_frame();
    chk("t3_rdata_bad", rdata, 40'hAB_1A_3C_04_88);
    chk("t3_bcc_bad", bcc_ok, 0);
    n0 = dn_n; e0 = er_n;
    frame(0, 6'h02, 0, 40'h0, 48'h0);
    repeat (3) @(posedge clk);
    frame(0, 6'h02, 6, 40'h0, 48'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("t4_err_pulses", er_n - e0, 2);
    chk("t4_no_done", dn_n - n0, 0);
    chk("t4_rdata_kept", rdata, 40'hAB_1A_3C_04_88);
    frame(1, 6'h09, 3, 40'h0, 48'h00_00_33_22_11_AA);
    repeat (37) @(posedge clk);
    #1;
    rst = 1; m_kill = cyc + 1; m_rdv = 0; m_bccv = 0;
    @(posedge clk); #1;
    chk("t5_cs", cs, 1);
    chk("t5_sck", sck, 0);
    chk("t5_busy", busy, 0);
    chk("t5_rdata", rdata, 40'h0);
    @(posedge clk); #1 rst = 0;
    frame(1, 6'h09, 3, 40'h0, 48'h00_00_66_55_44_AA);
    wait_frame();
    chk("t5_after_rdata", rdata, 40'h00_00_66_55_44);
    n0 = dn_n;
    frame(0, 6'h11, 2, 40'h5AC3, 48'h0);
    repeat (10) @(posedge clk);
    frame(1, 6'h3F, 1, 40'hFF_FF_FF_FF_FF, 48'h0);
    wait_frame();
    chk("t6_one_done", dn_n - n0, 1);
    ex = '{8'h22, 8'hC3, 8'h5A, 8'h00};
    for (int i = 0; i < 3; i++) chk("t6_mosi_byte", cap[i], ex[i]);
    chk("t6_rdata", rdata, 40'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
